// File: rtl/gram_array_ctrl.sv
// Sequencer for a row of DIMENSION Gram-matrix PEs: streams rows of A, skews them onto the lanes, flags results.
// Optional GRAM_PASS_GAP_EN inserts one bubble cycle after every pass (stride DIMENSION+1).
module gram_array_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIMENSION = 4,
    parameter int unsigned AW        = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       mem_rd,
    output logic [AW-1:0]              mem_addr,
    input  logic [DIMENSION*WIDTH-1:0] mem_data,
    output logic [DIMENSION*WIDTH-1:0] lane_a,
    output logic [DIMENSION*WIDTH-1:0] lane_b,
    output logic [DIMENSION-1:0]       lane_en,
    output logic [DIMENSION-1:0]       res_valid,
    output logic [AW-1:0]              res_col
);
    localparam logic [AW-1:0] LAST_IDX = AW'(DIMENSION - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state;
    logic [AW-1:0]       rd_col;
    logic                rd_q;
    logic [AW-1:0]       tag_col;
    logic                tag_last;
    logic [WIDTH-1:0]    row [DIMENSION];
    logic [WIDTH-1:0]    s0_b;
    logic [WIDTH-1:0]    la [DIMENSION];
    logic [WIDTH-1:0]    lb [DIMENSION];
    logic [DIMENSION-1:0] lane_last;
    logic [AW-1:0]       l_col [DIMENSION];

    // Job sequencer: issues reads (j outer, k inner) and tracks completion.
    always_ff @(posedge clk) begin
        if (!rst || abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            rd_col   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= '0;
                        rd_col   <= '0;
                    end
                end
                RUN: begin
                    if (mem_rd) begin
                        if (mem_addr == LAST_IDX) begin
                            if (rd_col == LAST_IDX) begin
                                state  <= DRAIN;
                                mem_rd <= 1'b0;
                            end else begin
                                rd_col   <= rd_col + AW'(1);
                                mem_addr <= '0;
`ifdef GRAM_PASS_GAP_EN
                                mem_rd   <= 1'b0;
`else
                                mem_rd   <= 1'b1;
`endif
                            end
                        end else begin
                            mem_addr <= mem_addr + AW'(1);
                        end
                    end else begin
                        mem_rd <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Last lane flagging the last column ends the job.
                    if (res_valid[DIMENSION-1] && res_col == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tags that travel with the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (!rst || abort) begin
            rd_q     <= 1'b0;
            tag_col  <= '0;
            tag_last <= 1'b0;
        end else begin
            rd_q     <= mem_rd;
            tag_col  <= rd_col;
            tag_last <= (mem_addr == LAST_IDX);
        end
    end

    assign s0_b = rd_q ? row[tag_col] : '0;

    for (genvar gi = 0; gi < DIMENSION; gi++) begin : g_lane
        logic [WIDTH-1:0] a0;

        assign row[gi] = mem_data[gi*WIDTH +: WIDTH];
        assign a0      = rd_q ? row[gi] : '0;

        if (gi == 0) begin : g_direct
            assign lane_en[0]   = rd_q;
            assign la[0]        = a0;
            assign lb[0]        = s0_b;
            assign lane_last[0] = rd_q & tag_last;
            assign l_col[0]     = tag_col;
        end else begin : g_chain
            logic [WIDTH-1:0] ca [gi];
            logic [WIDTH-1:0] cb [gi];
            logic [AW-1:0]    cc [gi];
            logic             ce [gi];
            logic             cl [gi];

            // Lane gi sees the row gi cycles late; operands are pre-zeroed when idle.
            always_ff @(posedge clk) begin
                if (!rst || abort) begin
                    for (int d = 0; d < gi; d++) begin
                        ca[d] <= '0;
                        cb[d] <= '0;
                        cc[d] <= '0;
                        ce[d] <= 1'b0;
                        cl[d] <= 1'b0;
                    end
                end else begin
                    ca[0] <= a0;
                    cb[0] <= s0_b;
                    cc[0] <= tag_col;
                    ce[0] <= rd_q;
                    cl[0] <= rd_q & tag_last;
                    for (int d = 1; d < gi; d++) begin
                        ca[d] <= ca[d-1];
                        cb[d] <= cb[d-1];
                        cc[d] <= cc[d-1];
                        ce[d] <= ce[d-1];
                        cl[d] <= cl[d-1];
                    end
                end
            end

            assign lane_en[gi]   = ce[gi-1];
            assign la[gi]        = ca[gi-1];
            assign lb[gi]        = cb[gi-1];
            assign lane_last[gi] = cl[gi-1];
            assign l_col[gi]     = cc[gi-1];
        end

        assign lane_a[gi*WIDTH +: WIDTH] = la[gi];
        assign lane_b[gi*WIDTH +: WIDTH] = lb[gi];
    end

    // Result flag follows each lane's final accumulate of a pass.
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_valid <= '0;
            res_col   <= '0;
        end else if (abort) begin
            res_valid <= '0;
        end else begin
            res_valid <= lane_last;
            for (int i = 0; i < int'(DIMENSION); i++) begin
                if (lane_last[i]) begin
                    res_col <= l_col[i];
                end
            end
        end
    end
endmodule
